instr_aligner: RTL
==================

# instr_aligner

Fetch-side parcel aligner that sits between the instruction fetch port and `instr_decompressor`. It accepts word-aligned 32-bit fetch words and buffers their 16-bit parcels. Each cycle it emits at most one complete instruction, either a 16-bit compressed one or a 32-bit one, together with its PC and a compressed flag. It handles 32-bit instructions that straddle two fetch words, and flush/redirect to halfword-aligned targets.

## Interface
- `PC_WIDTH`, 64, width of PC values
- `RESET_PC`, 0, head PC after reset; bit 0 must be 0
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  reset; asynchronous, active-low. Design has one clock; reset polarity and synchronicity are fixed.
- `i_flush`  in  1  discard buffer and redirect to `i_flush_pc`
- `i_flush_pc`  in  PC_WIDTH  redirect target, halfword aligned
- `i_fetch_valid`  in  1  fetch word present
- `o_fetch_ready`  out  1  aligner can accept the word
- `i_fetch_word`  in  32  fetch data, little-endian: parcel0 = [15:0], parcel1 = [31:16]
- `o_valid`  out  1  complete instruction at head
- `i_ready`  in  1  consumer (decompressor/decode) takes the head instruction
- `o_instr`  out  32  raw instruction; `{16'b0, p0}` when compressed, `{p1, p0}` otherwise
- `o_compressed`  out  1  head parcel has `[1:0] != 2'b11`
- `o_pc`  out  PC_WIDTH  PC of the head instruction

## Operation
- Buffer: 3 × 16-bit parcels in FIFO order, plus `count` (0..3), head PC `pc_q`, and `skip_q`.
- Accept: `o_fetch_ready = (count <= 1) & ~i_flush`. A push happens on `i_fetch_valid & o_fetch_ready`.
  - Push appends parcel0 then parcel1.
  - If `skip_q` is set, parcel0 is dropped, only parcel1 is appended, and `skip_q` clears.
- Output: `o_valid = (count >= 1 & p0[1:0] != 2'b11) | (count >= 2)`.
  - A 32-bit instruction with only one parcel buffered waits for the next word.
- Pop on `o_valid & i_ready`: remove 1 parcel (compressed) or 2 parcels (full); `pc_q += 2` or `+= 4`, modulo 2^PC_WIDTH.
- Push and pop in the same cycle are legal.
  - New count = count − popped + pushed.
  - Pushed parcels land behind the surviving ones.
  - The pop decision uses pre-push buffer contents.
- Flush (highest priority):
  - `count ← 0`, `pc_q ← i_flush_pc`, `skip_q ← i_flush_pc[1]`.
  - Any pop or push in that cycle is ignored; `o_valid` may still be 1 in that cycle, but the consumer must not rely on it.
- Reset: `count = 0`, `pc_q = RESET_PC`, `skip_q = RESET_PC[1]`, parcel storage = 0.
  - Resulting outputs: `o_valid = 0`, `o_fetch_ready = 1`, `o_instr = 0`, `o_compressed = 0`, `o_pc = RESET_PC`.
- The 48-bit-and-longer encodings (`[4:2] == 3'b111` with `[1:0] == 2'b11`) are not recognized; they are emitted as 32-bit instructions and rejected downstream.

## Timing
- All state is registered; all outputs are combinational from registers only, with no input→output paths except `o_fetch_ready` from `i_flush`.
- Latency: word accepted at edge N → its first instruction has `o_valid` in cycle N+1.
- Throughput: one instruction per cycle sustained, as long as words arrive.
- Straddling instruction: visible in the cycle after the second word is accepted.
- `count == 3`: fetch stalls until a pop brings `count` to ≤1.
- `count == 1` with a 32-bit head: `o_valid = 0`, `o_fetch_ready = 1`.
- Reset asserted mid-operation: immediate return to the reset state; nothing is emitted afterwards from pre-reset data.

## Structure
- Shared package:
  - `PARCEL_W = 16`
  - function `is_compressed(parcel)` (`[1:0] != 2'b11`), reused by the decompressor and decode
- No sub-module is required. An optional `parcel_fifo` (3-deep, pop-1/pop-2, push-1/push-2) is natural if reused for prefetch.

## Test plan
- Reset, then word `0x00010001` → two instructions `0x00000001`, compressed = 1, PC 0 then 2; then `o_valid = 0`.
- Word `0x00000013` → one instruction `0x00000013`, compressed = 0, PC 0; next head PC 4.
- Word `0x00130001` then `0x00000000` → `0x00000001` at PC 0; then `0x00000013` at PC 2, emitted the cycle after the second word is accepted.
- Flush to `0x102`, then word `0x45010001` → parcel `0x0001` dropped; one instruction `0x00004501` at PC `0x102`.
- Hold `i_ready = 0` with three compressed parcels buffered → `o_fetch_ready = 0`; outputs stable across ≥5 cycles; release → drains at one instruction per cycle.
- Assert `i_rst_n = 0` with `count = 2` → outputs immediately at their reset values; first instruction after release has PC `RESET_PC`.

Source files
------------

// File: rtl/instr_aligner_pkg.sv
// Shared definitions for the fetch-side parcel aligner and its consumers.
// is_compressed() is shared with the decompressor and decode so that all three agree on the encoding.
package instr_aligner_pkg;

  localparam int unsigned PARCEL_W = 16;
  localparam int unsigned DEPTH    = 3;

  typedef logic [PARCEL_W-1:0] parcel_t;

  // Number of parcels moved into or out of the parcel buffer in one cycle.
  typedef enum logic [1:0] {
    MOVE_NONE = 2'd0,
    MOVE_ONE  = 2'd1,
    MOVE_TWO  = 2'd2
  } move_e;

  function automatic logic is_compressed(input parcel_t parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/instr_aligner_parcel_fifo.sv
// Three-deep parcel buffer with pop-1/pop-2 and push-1/push-2 in the same cycle.
// Pushed parcels land behind whatever survives the pop.
module parcel_fifo
  import instr_aligner_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  move_e      pop,
  input  move_e      push,
  input  parcel_t    push_lo,
  input  parcel_t    push_hi,
  output parcel_t    head0,
  output parcel_t    head1,
  output logic [1:0] count
);

  parcel_t    mem_q [DEPTH];
  parcel_t    mem_d [DEPTH];
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic [1:0] base;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    base    = count_q - pop;
    if (clear) begin
      count_d = '0;
    end else begin
      unique case (pop)
        MOVE_ONE: begin
          mem_d[0] = mem_q[1];
          mem_d[1] = mem_q[2];
        end
        MOVE_TWO: mem_d[0] = mem_q[2];
        default: ;
      endcase
      // The owner only pushes when at most one parcel is buffered, so base <= 1 here.
      if (push != MOVE_NONE) begin
        unique case (base)
          2'd0: begin
            mem_d[0] = push_lo;
            if (push == MOVE_TWO) mem_d[1] = push_hi;
          end
          2'd1: begin
            mem_d[1] = push_lo;
            if (push == MOVE_TWO) mem_d[2] = push_hi;
          end
          2'd2: mem_d[2] = push_lo;
          default: ;
        endcase
      end
      count_d = base + push;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign head0 = mem_q[0];
  assign head1 = mem_q[1];
  assign count = count_q;

endmodule

// File: rtl/instr_aligner.sv
// Fetch-side parcel aligner: turns word-aligned 32-bit fetch words into one
// compressed or full instruction per cycle, with its PC, across word boundaries.
module instr_aligner
  import instr_aligner_pkg::*;
#(
  parameter int unsigned           PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic [PC_WIDTH-1:0] i_flush_pc,
  input  logic                i_fetch_valid,
  output logic                o_fetch_ready,
  input  logic [31:0]         i_fetch_word,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [31:0]         o_instr,
  output logic                o_compressed,
  output logic [PC_WIDTH-1:0] o_pc
);

  logic [PC_WIDTH-1:0] pc_q;
  logic                skip_q;
  parcel_t             head0;
  parcel_t             head1;
  parcel_t             push_lo;
  parcel_t             push_hi;
  logic [1:0]          count;
  logic                head_c;
  logic                accept;
  logic                fire;
  move_e               pop;
  move_e               push;

  assign head_c        = is_compressed(head0);
  assign o_fetch_ready = (count <= 2'd1) & ~i_flush;
  assign accept        = i_fetch_valid & o_fetch_ready;
  assign o_valid       = ((count != 2'd0) & head_c) | (count >= 2'd2);
  assign fire          = o_valid & i_ready & ~i_flush;

  // Gated by count so an empty buffer of reset zeros does not read as compressed.
  assign o_compressed  = (count != 2'd0) & head_c;
  assign o_instr       = o_compressed ? {16'b0, head0} : {head1, head0};
  assign o_pc          = pc_q;

  always_comb begin
    pop     = MOVE_NONE;
    push    = MOVE_NONE;
    push_lo = i_fetch_word[15:0];
    push_hi = i_fetch_word[31:16];
    if (fire) pop = head_c ? MOVE_ONE : MOVE_TWO;
    if (accept) begin
      // Redirect to an odd halfword: the first parcel of the word precedes the target.
      if (skip_q) begin
        push    = MOVE_ONE;
        push_lo = i_fetch_word[31:16];
      end else begin
        push    = MOVE_TWO;
      end
    end
  end

  parcel_fifo u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clear   (i_flush),
    .pop     (pop),
    .push    (push),
    .push_lo (push_lo),
    .push_hi (push_hi),
    .head0   (head0),
    .head1   (head1),
    .count   (count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q   <= RESET_PC;
      skip_q <= RESET_PC[1];
    end else if (i_flush) begin
      pc_q   <= i_flush_pc;
      skip_q <= i_flush_pc[1];
    end else begin
      if (fire) pc_q <= pc_q + (head_c ? PC_WIDTH'(2) : PC_WIDTH'(4));
      if (accept) skip_q <= 1'b0;
    end
  end

endmodule
